// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter family: index-width helper,
// channel-count ceiling and the channel-index typedef pattern.
package arb_pkg;

    localparam int ARB_MAX_N = 16;

    // Width of a channel index; never narrower than one bit so N=1 still has a port.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            r = ((32'd1 << i) < n) ? (i + 1) : r;
        end
        return (r < 1) ? 1 : r;
    endfunction

    typedef logic [clog2_min1(ARB_MAX_N)-1:0] arb_idx_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches req from ptr upwards with wrap.
// With lock set, only the channel at ptr may be granted.
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int N = 4,
    localparam int SEL_W = clog2_min1(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             lock,
    output logic [N-1:0]     grant,
    output logic [SEL_W-1:0] idx
);

    logic found_s;
    logic hit_s;
    int   ch_s;

    // First requester at or after ptr (modulo N) wins; each channel is visited once.
    always_comb begin
        grant   = {N{1'b0}};
        idx     = {SEL_W{1'b0}};
        found_s = 1'b0;
        hit_s   = 1'b0;
        ch_s    = 0;
        for (int k = 0; k < N; k++) begin
            ch_s        = int'(ptr) + k;
            ch_s        = (ch_s >= N) ? (ch_s - N) : ch_s;
            hit_s       = !found_s && req[ch_s] && (!lock || (k == 0));
            grant[ch_s] = hit_s;
            idx         = hit_s ? SEL_W'(ch_s) : idx;
            found_s     = found_s | hit_s;
        end
    end

endmodule

// File: rtl/arb_mux_rr.sv
// N-channel valid/ready round-robin merge with a registered output stage.
// Define ARB_MUX_LOCK_EN to add in_last and hold the grant for multi-beat packets.
module arb_mux_rr
    import arb_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N     = 4,
    localparam int SEL_W = clog2_min1(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
`ifdef ARB_MUX_LOCK_EN
    input  logic [N-1:0]       in_last,
`endif
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SEL_W-1:0]   out_sel
);

    typedef logic [SEL_W-1:0] sel_t;

    sel_t       ptr_r;
    sel_t       arb_ptr_s;
    sel_t       idx_s;
    sel_t       ptr_nxt_s;
    logic [N-1:0] grant_s;
    logic       load_en_s;
    logic       take_s;
    logic       lock_s;

`ifdef ARB_MUX_LOCK_EN
    logic       lock_r;
    sel_t       lock_ch_r;
    assign lock_s    = lock_r;
    assign arb_ptr_s = lock_r ? lock_ch_r : ptr_r;
`else
    assign lock_s    = 1'b0;
    assign arb_ptr_s = ptr_r;
`endif

    rr_arbiter #(.N(N)) u_arb (
        .req   (in_valid),
        .ptr   (arb_ptr_s),
        .lock  (lock_s),
        .grant (grant_s),
        .idx   (idx_s)
    );

    // Loading while draining keeps one transfer per cycle without a bubble.
    assign load_en_s = !out_valid || out_ready;
    assign take_s    = load_en_s && (|grant_s);
    assign in_ready  = rst_n ? (grant_s & {N{load_en_s}}) : {N{1'b0}};
    assign ptr_nxt_s = (idx_s == sel_t'(N - 1)) ? {SEL_W{1'b0}} : (idx_s + sel_t'(1));

    // Output register, priority pointer and packet lock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= {WIDTH{1'b0}};
            out_sel   <= {SEL_W{1'b0}};
            ptr_r     <= {SEL_W{1'b0}};
`ifdef ARB_MUX_LOCK_EN
            lock_r    <= 1'b0;
            lock_ch_r <= {SEL_W{1'b0}};
`endif
        end else if (load_en_s) begin
            out_valid <= take_s;
            if (take_s) begin
                out_data <= in_data[int'(idx_s)*WIDTH +: WIDTH];
                out_sel  <= idx_s;
`ifdef ARB_MUX_LOCK_EN
                if (in_last[idx_s]) begin
                    ptr_r  <= ptr_nxt_s;
                    lock_r <= 1'b0;
                end else begin
                    lock_r    <= 1'b1;
                    lock_ch_r <= idx_s;
                end
`else
                ptr_r <= ptr_nxt_s;
`endif
            end
        end
    end

endmodule
